// File: rtl/mux6_bit_serializer_if.sv
// Word-in / bit-out stream bundle for mux6_bit_serializer.
// The master drives words in and takes serial bits out; the slave is the serializer.
interface mux6_bit_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       ser_valid;
  logic       ser_data;
  logic       ser_last;
  logic       ser_ready;

  modport master (
    output in_valid,
    output in_data,
    output ser_ready,
    input  in_ready,
    input  ser_valid,
    input  ser_data,
    input  ser_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ser_ready,
    output in_ready,
    output ser_valid,
    output ser_data,
    output ser_last
  );
endinterface

// File: rtl/mux6_bit_serializer.sv
// Serializes a 6-bit word through an external 6:1 bit-select mux, holding each
// select for HOLD_CYCLES before sampling mux_out into a valid/ready bit stream.
module mux6_bit_serializer #(
  parameter bit          MSB_FIRST   = 1'b0,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mux6_bit_serializer_if.slave  bus,
  output logic [5:0]            mux_din,
  output logic [2:0]            mux_sel,
  input  logic                  mux_out,
  output logic                  busy
);

  generate
    if (HOLD_CYCLES == 0) begin : g_bad_hold
      $error("mux6_bit_serializer: HOLD_CYCLES must be at least 1");
    end
  endgenerate

  localparam int unsigned HoldW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES - 1);
  localparam logic [2:0]  FirstLane = MSB_FIRST ? 3'd5 : 3'd0;
  localparam logic [2:0]  LastBit   = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StEmit
  } state_e;

  state_e           state_q;
  logic [5:0]       mux_din_q;
  logic [2:0]       mux_sel_q;
  logic [HoldW-1:0] hold_q;
  logic [2:0]       bit_q;
  logic             ser_valid_q;
  logic             ser_data_q;
  logic             ser_last_q;
  logic             busy_q;
  logic [2:0]       next_sel;

  // Lane walk never leaves 0..5: six bits visited, the step after the last is never taken.
  assign next_sel = MSB_FIRST ? (mux_sel_q - 3'd1) : (mux_sel_q + 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mux_din_q   <= '0;
      mux_sel_q   <= '0;
      hold_q      <= '0;
      bit_q       <= '0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            mux_din_q <= bus.in_data;
            mux_sel_q <= FirstLane;
            hold_q    <= HoldInit;
            bit_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (hold_q == '0) begin
            ser_data_q  <= mux_out;
            ser_valid_q <= 1'b1;
            ser_last_q  <= (bit_q == LastBit);
            state_q     <= StEmit;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        StEmit: begin
          if (bus.ser_ready) begin
            ser_valid_q <= 1'b0;
            if (bit_q == LastBit) begin
              ser_last_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end else begin
              mux_sel_q <= next_sel;
              bit_q     <= bit_q + 3'd1;
              hold_q    <= HoldInit;
              state_q   <= StSettle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_last  = ser_last_q;
  assign mux_din       = mux_din_q;
  assign mux_sel       = mux_sel_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mux6_bit_serializer.sv
// Bench for mux6_bit_serializer: LSB-first/HOLD=1 and MSB-first/HOLD=2 instances, each
// looped through a 6:1 mux, checked against a word-level expected bit order and timing.
module tb_mux6_bit_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Stimulus steered to one instance at a time.
  logic       sel_b = 1'b0;
  logic       drv_valid = 1'b0;
  logic [5:0] drv_data = '0;
  logic       drv_ready = 1'b1;

  mux6_bit_serializer_if a_if ();
  mux6_bit_serializer_if b_if ();
  logic [5:0] a_din, b_din;
  logic [2:0] a_sel, b_sel;
  logic       a_mux_out, b_mux_out, a_busy, b_busy;

  assign a_if.in_valid  = sel_b ? 1'b0 : drv_valid;
  assign a_if.in_data   = drv_data;
  assign a_if.ser_ready = sel_b ? 1'b0 : drv_ready;
  assign b_if.in_valid  = sel_b ? drv_valid : 1'b0;
  assign b_if.in_data   = drv_data;
  assign b_if.ser_ready = sel_b ? drv_ready : 1'b0;

  // The 6:1 bit-select mux the serializer drives.
  assign a_mux_out = (a_sel < 3'd6) ? a_din[a_sel] : 1'b0;
  assign b_mux_out = (b_sel < 3'd6) ? b_din[b_sel] : 1'b0;

  mux6_bit_serializer #(.MSB_FIRST(1'b0), .HOLD_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .bus(a_if), .mux_din(a_din), .mux_sel(a_sel),
    .mux_out(a_mux_out), .busy(a_busy)
  );
  mux6_bit_serializer #(.MSB_FIRST(1'b1), .HOLD_CYCLES(2)) u_b (
    .clk(clk), .reset(reset), .bus(b_if), .mux_din(b_din), .mux_sel(b_sel),
    .mux_out(b_mux_out), .busy(b_busy)
  );

  logic       o_in_ready, o_valid, o_data, o_last, o_busy;
  logic [5:0] o_din;
  logic [2:0] o_sel;
  assign o_in_ready = sel_b ? b_if.in_ready  : a_if.in_ready;
  assign o_valid    = sel_b ? b_if.ser_valid : a_if.ser_valid;
  assign o_data     = sel_b ? b_if.ser_data  : a_if.ser_data;
  assign o_last     = sel_b ? b_if.ser_last  : a_if.ser_last;
  assign o_busy     = sel_b ? b_busy : a_busy;
  assign o_din      = sel_b ? b_din  : a_din;
  assign o_sel      = sel_b ? b_sel  : a_sel;

  int checks = 0;
  int errors = 0;
  int cur_hold = 1;
  bit cur_msb = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_sel"}, 32'(o_sel), 0);
    check({tag, "_din"}, 32'(o_din), 0);
    check({tag, "_data"}, 32'(o_data), 0);
    check({tag, "_last"}, 32'(o_last), 0);
    check({tag, "_in_ready"}, 32'(o_in_ready), 1);
  endtask

  // Sends one word and checks every bit against the lane order and the settle timing.
  // stall_at: bit index where ser_ready drops for stall_len cycles (-1: none).
  // poke: hold in_valid with 6'h3F while busy. abort_at: reset while that bit is valid.
  task automatic run_word(input logic [5:0] word, input int stall_at, input int stall_len,
                          input bit poke, input int abort_at);
    int n;
    int total;
    int lane;
    n = 0;
    while (!o_in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_pre", 32'(o_in_ready), 1);
    drv_valid = 1'b1;
    drv_data  = word;
    tick();
    drv_valid = poke;
    drv_data  = poke ? 6'h3F : 6'($urandom);
    check("accept_busy", 32'(o_busy), 1);
    check("accept_din", 32'(o_din), 32'(word));
    check("first_sel", 32'(o_sel), cur_msb ? 5 : 0);
    check("accept_in_ready", 32'(o_in_ready), 0);
    total = 0;
    for (int k = 0; k < 6; k++) begin
      lane = cur_msb ? 5 - k : k;
      n = 0;
      while (!o_valid && n < 50) begin
        tick();
        n++;
      end
      total += n;
      check("settle_cycles", 32'(n), 32'(cur_hold));
      check("ser_valid", 32'(o_valid), 1);
      check("ser_data", 32'(o_data), 32'(word[lane]));
      check("mux_sel", 32'(o_sel), 32'(lane));
      check("ser_last", 32'(o_last), (k == 5) ? 1 : 0);
      check("din_held", 32'(o_din), 32'(word));
      check("busy_in_ready", 32'(o_in_ready), 0);
      if (k == abort_at) begin
        #1 reset = 1'b1;
        #1 check_reset_vals("reset_mid");
        drv_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        return;
      end
      if (k == stall_at) begin
        drv_ready = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          tick();
          total++;
          check("stall_valid", 32'(o_valid), 1);
          check("stall_data", 32'(o_data), 32'(word[lane]));
          check("stall_sel", 32'(o_sel), 32'(lane));
          check("stall_last", 32'(o_last), (k == 5) ? 1 : 0);
        end
        drv_ready = 1'b1;
      end
      tick();
      total++;
      check("hs_valid_drop", 32'(o_valid), 0);
    end
    check("word_cycles", 32'(total),
          32'(6 * (cur_hold + 1) + ((stall_at >= 0 && stall_at < 6) ? stall_len : 0)));
    check("in_ready_post", 32'(o_in_ready), 1);
    check("busy_post", 32'(o_busy), 0);
    check("last_post", 32'(o_last), 0);
  endtask

  initial begin
    // Reset state, both instances.
    repeat (2) tick();
    check_reset_vals("reset_a");
    sel_b = 1'b1;
    #1 check_reset_vals("reset_b");
    sel_b = 1'b0;
    reset = 1'b0;
    tick();

    // LSB first, HOLD=1.
    cur_msb = 1'b0;
    cur_hold = 1;
    run_word(6'b001101, -1, 0, 1'b0, -1);
    run_word(6'b001101, 2, 5, 1'b0, -1);
    run_word(6'b001101, -1, 0, 1'b1, -1);
    run_word(6'b111111, -1, 0, 1'b0, -1);
    run_word(6'($urandom), -1, 0, 1'b0, 3);
    run_word(6'b000001, -1, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      run_word(6'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(1, 4)), 1'b0, -1);
    end

    // MSB first, HOLD=2.
    drv_valid = 1'b0;
    tick();
    sel_b = 1'b1;
    cur_msb = 1'b1;
    cur_hold = 2;
    #1;
    run_word(6'b100101, -1, 0, 1'b0, -1);
    run_word(6'b100101, 3, 3, 1'b0, -1);
    run_word(6'($urandom), -1, 0, 1'b0, 2);
    run_word(6'b100000, -1, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      run_word(6'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(1, 4)), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
